led_mmio: RTL and testbench

- Memory-mapped LED peripheral on the hxd32 data-memory write bus, downstream of the CPU store port, in parallel with the data RAM.
- Decodes stores into a small register window.
- Drives the board's 8 water LEDs and two 7-segment digits, with hex decode and a ms-tick blink engine.
- Provides a 1-cycle-latency register read port for a future load-mux.

---
 rtl/led_mmio.sv | 244 ++++++++++++++++++++++++
 tb/tb_led_mmio.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mmio.sv
// led_mmio: memory-mapped LED peripheral sitting on the hxd32 data-memory write bus.
//
// Stores whose address falls in a 16-byte window at BASE_ADDR update a small register file.
// The registers drive 8 water LEDs and two 7-segment digits.
// A ms-tick blink engine can periodically blank both the LEDs and the digits.
//
// Register map (byte offset, addr[3:2] selects):
//   0x0 LED    [7:0]  led pattern
//   0x4 SEG    [3:0] digit1, [4] dp1, [11:8] digit2, [12] dp2, [16] seg_en, [17] raw
//              raw mode: [6:0] digit1 segments, [14:8] digit2 segments
//   0x8 BLINK  [15:0] half-period in ticks, [16] blink_en
//   0xC STATUS [0] phase, [31:16] blink count (read-only)
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   wr_en_i/wr_addr_i/
//   wr_data_i/wr_byte_en_i    CPU store port (shared with the data RAM)
//   rd_en_i/rd_addr_i         register read request
//   rd_data_o/rd_vld_o        read response, one cycle after rd_en_i
//   water_led_o               LED drive, 1 = on
//   segment_led_1_o/_2_o      {common (0 = on), dp, g..a}
//
// Read protocol: there is no back-pressure. Every cycle with rd_en_i high is answered
// exactly one cycle later by a single-cycle rd_vld_o pulse. rd_data_o carries the
// register value as it stood at the rd_en_i edge, or 0 for an address outside the
// window. Between responses rd_data_o holds its last value.
module led_mmio #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  BASE_ADDR = 32'h0001_0000,
  parameter int               TICK_DIV  = 12000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [3:0]      wr_byte_en_i,
  input  logic            rd_en_i,
  input  logic [XLEN-1:0] rd_addr_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_vld_o,
  output logic [7:0]      water_led_o,
  output logic [8:0]      segment_led_1_o,
  output logic [8:0]      segment_led_2_o
);

  // Implemented bits of each register; everything else stores and reads as 0.
  localparam logic [XLEN-1:0] LED_MASK   = XLEN'(32'h0000_00FF);
  localparam logic [XLEN-1:0] SEG_MASK   = XLEN'(32'h0003_7F7F);
  localparam logic [XLEN-1:0] BLINK_MASK = XLEN'(32'h0001_FFFF);

  localparam int              PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(TICK_DIV - 1);

  localparam logic [8:0]      SEG_OFF  = 9'h100;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic       wr_hit;
  logic       rd_hit;
  logic [1:0] wr_sel;
  logic [1:0] rd_sel;

  assign wr_hit = (wr_addr_i[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign rd_hit = (rd_addr_i[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
  assign wr_sel = wr_addr_i[3:2];
  assign rd_sel = rd_addr_i[3:2];

  logic led_wr;
  logic seg_wr;
  logic blink_wr;

  assign led_wr   = wr_en_i & wr_hit & (wr_sel == 2'd0);
  assign seg_wr   = wr_en_i & wr_hit & (wr_sel == 2'd1);
  assign blink_wr = wr_en_i & wr_hit & (wr_sel == 2'd2);

  // Byte-lane merge of a store into an existing register value.
  function automatic logic [XLEN-1:0] merge_bytes(
    input logic [XLEN-1:0] old_val,
    input logic [XLEN-1:0] new_val,
    input logic [3:0]      be,
    input logic [XLEN-1:0] mask
  );
    logic [XLEN-1:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r & mask;
  endfunction

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] led_q;
  logic [XLEN-1:0] seg_q;
  logic [XLEN-1:0] blink_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      led_q   <= '0;
      seg_q   <= '0;
      blink_q <= '0;
    end else begin
      if (led_wr)   led_q   <= merge_bytes(led_q,   wr_data_i, wr_byte_en_i, LED_MASK);
      if (seg_wr)   seg_q   <= merge_bytes(seg_q,   wr_data_i, wr_byte_en_i, SEG_MASK);
      if (blink_wr) blink_q <= merge_bytes(blink_q, wr_data_i, wr_byte_en_i, BLINK_MASK);
    end
  end

  // ---------------------------------------------------------------------------
  // Tick prescaler and blink engine
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_q;
  logic          tick;
  logic [15:0]   half_period;
  logic          blink_en;
  logic          blink_active;
  logic [15:0]   cnt_q;
  logic          phase_q;

  assign tick         = (pre_q == PRE_LAST);
  assign half_period  = blink_q[15:0];
  assign blink_en     = blink_q[16];
  assign blink_active = blink_en & (half_period != 16'd0);

  // A BLINK store restarts the whole engine so a new half-period begins
  // cleanly from a lit phase, regardless of where the prescaler was.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (blink_wr) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (!blink_active) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else if (tick) begin
        if (cnt_q == half_period - 16'd1) begin
          cnt_q   <= '0;
          phase_q <= ~phase_q;
        end else begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
    end
  end

  logic [XLEN-1:0] status;

  always_comb begin
    status        = '0;
    status[0]     = phase_q;
    status[31:16] = cnt_q;
  end

  // ---------------------------------------------------------------------------
  // Segment decode and registered outputs
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic       blank;
  logic       seg_en;
  logic       seg_raw;
  logic [6:0] seg7_1;
  logic [6:0] seg7_2;

  assign blank   = blink_en & phase_q;
  assign seg_en  = seg_q[16];
  assign seg_raw = seg_q[17];
  assign seg7_1  = seg_raw ? seg_q[6:0]  : hex7(seg_q[3:0]);
  assign seg7_2  = seg_raw ? seg_q[14:8] : hex7(seg_q[11:8]);

  // dp bits stay at [4] and [12] in raw mode too; raw patterns that need a
  // dark dp keep segment e of the value clear, which is the same bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      water_led_o     <= '0;
      segment_led_1_o <= SEG_OFF;
      segment_led_2_o <= SEG_OFF;
    end else begin
      water_led_o     <= led_q[7:0] & {8{~blank}};
      segment_led_1_o <= (seg_en & ~blank) ? {1'b0, seg_q[4],  seg7_1} : SEG_OFF;
      segment_led_2_o <= (seg_en & ~blank) ? {1'b0, seg_q[12], seg7_2} : SEG_OFF;
    end
  end

  // ---------------------------------------------------------------------------
  // Read port
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    if (rd_hit) begin
      case (rd_sel)
        2'd0:    rd_val = led_q;
        2'd1:    rd_val = seg_q;
        2'd2:    rd_val = blink_q;
        default: rd_val = status;
      endcase
    end
  end

  // Sampling the current (pre-update) registers means a read that coincides
  // with a store to the same register returns the old value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_vld_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_vld_o <= rd_en_i;
      if (rd_en_i) rd_data_o <= rd_val;
    end
  end

endmodule

// File: tb/tb_led_mmio.sv
module tb_led_mmio;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_vld;
  logic [7:0]  water;
  logic [8:0]  seg1;
  logic [8:0]  seg2;

  int n_cmp = 0;
  int n_bad = 0;

  led_mmio #(
    .XLEN(32),
    .BASE_ADDR(BASE),
    .TICK_DIV(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .wr_en_i(wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .wr_byte_en_i(wr_be),
    .rd_en_i(rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data),
    .rd_vld_o(rd_vld),
    .water_led_o(water),
    .segment_led_1_o(seg1),
    .segment_led_2_o(seg2)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  // Hand-written hex segment table (a = bit0).
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0; wr_be = 4'h0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic vld, output logic [31:0] data);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = addr;
    @(negedge clk);
    rd_en = 1'b0;
    vld  = rd_vld;
    data = rd_data;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (water !== 8'h00) begin n_bad++; $display("FAIL reset_water got=%h exp=00", water); end
    n_cmp++; if (seg1 !== 9'h100) begin n_bad++; $display("FAIL reset_seg1 got=%h exp=100", seg1); end
    n_cmp++; if (seg2 !== 9'h100) begin n_bad++; $display("FAIL reset_seg2 got=%h exp=100", seg2); end
    n_cmp++; if (rd_vld !== 1'b0) begin n_bad++; $display("FAIL reset_rd_vld got=%b exp=0", rd_vld); end
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_led;
    do_write(BASE, 32'h0000_00A5, 4'b0001);
    n_cmp++; if (water !== 8'h00) begin n_bad++; $display("FAIL led_early got=%h exp=00", water); end
    @(negedge clk);
    n_cmp++; if (water !== 8'hA5) begin n_bad++; $display("FAIL led_write got=%h exp=a5", water); end
    do_write(BASE + 32'h10, 32'h0000_0033, 4'b1111);
    @(negedge clk);
    n_cmp++; if (water !== 8'hA5) begin n_bad++; $display("FAIL led_miss got=%h exp=a5", water); end
    do_write(BASE, 32'h0000_0011, 4'b0000);
    @(negedge clk);
    n_cmp++; if (water !== 8'hA5) begin n_bad++; $display("FAIL led_no_be got=%h exp=a5", water); end
    // addr[1:0] ignored
    do_write(BASE + 32'h3, 32'h0000_003C, 4'b0001);
    @(negedge clk);
    n_cmp++; if (water !== 8'h3C) begin n_bad++; $display("FAIL led_low_addr got=%h exp=3c", water); end
  endtask

  task automatic test_seg;
    do_write(BASE + 32'h4, 32'h0001_1B03, 4'b1111);
    @(negedge clk);
    n_cmp++; if (seg1 !== 9'h04F) begin n_bad++; $display("FAIL seg_3 got=%h exp=04f", seg1); end
    n_cmp++; if (seg2 !== 9'h0FC) begin n_bad++; $display("FAIL seg_b_dp got=%h exp=0fc", seg2); end
    do_write(BASE + 32'h4, 32'h0000_0000, 4'b0100);
    @(negedge clk);
    n_cmp++; if (seg1 !== 9'h100) begin n_bad++; $display("FAIL seg_off1 got=%h exp=100", seg1); end
    n_cmp++; if (seg2 !== 9'h100) begin n_bad++; $display("FAIL seg_off2 got=%h exp=100", seg2); end
    // raw mode: digit1 = 0x23, digit2 = 0x49, dp bits clear
    do_write(BASE + 32'h4, 32'h0003_4923, 4'b1111);
    @(negedge clk);
    n_cmp++; if (seg1 !== 9'h023) begin n_bad++; $display("FAIL seg_raw1 got=%h exp=023", seg1); end
    n_cmp++; if (seg2 !== 9'h049) begin n_bad++; $display("FAIL seg_raw2 got=%h exp=049", seg2); end
  endtask

  task automatic test_hex;
    logic [31:0] d;
    for (int v = 0; v < 16; v++) begin
      d = 32'h0001_0000 | (32'(15 - v) << 8) | 32'(v);
      do_write(BASE + 32'h4, d, 4'b1111);
      @(negedge clk);
      n_cmp++;
      if (seg1 !== {2'b00, hex_tab[v]}) begin
        n_bad++; $display("FAIL hex1_%0d got=%h exp=%h", v, seg1, {2'b00, hex_tab[v]});
      end
      n_cmp++;
      if (seg2 !== {2'b00, hex_tab[15 - v]}) begin
        n_bad++; $display("FAIL hex2_%0d got=%h exp=%h", v, seg2, {2'b00, hex_tab[15 - v]});
      end
    end
  endtask

  task automatic test_blink;
    logic        dark;
    logic [31:0] exp_st;
    logic [31:0] got;
    logic        vld;
    do_write(BASE, 32'h0000_00FF, 4'b0001);
    do_write(BASE + 32'h4, 32'h0001_1B03, 4'b1111);
    do_write(BASE + 32'h8, 32'h0001_0003, 4'b1111);
    // STATUS read every cycle; the response at edge k reflects state after edge k-1.
    rd_en = 1'b1; rd_addr = BASE + 32'hC;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      dark = (((k - 1) / 12) % 2) == 1;
      n_cmp++;
      if (water !== (dark ? 8'h00 : 8'hFF)) begin
        n_bad++; $display("FAIL blink_led_k%0d got=%h exp=%h", k, water, dark ? 8'h00 : 8'hFF);
      end
      n_cmp++;
      if (seg1 !== (dark ? 9'h100 : 9'h04F)) begin
        n_bad++; $display("FAIL blink_seg_k%0d got=%h exp=%h", k, seg1, dark ? 9'h100 : 9'h04F);
      end
      exp_st = '0;
      exp_st[31:16] = 16'(((k - 1) / 4) % 3);
      exp_st[0]     = 1'(((k - 1) / 12) % 2);
      n_cmp++;
      if (rd_data !== exp_st) begin
        n_bad++; $display("FAIL blink_status_k%0d got=%h exp=%h", k, rd_data, exp_st);
      end
    end
    rd_en = 1'b0;
    // Now in a dark phase: rewriting BLINK relights on the following output update.
    do_write(BASE + 32'h8, 32'h0001_0003, 4'b1111);
    n_cmp++; if (water !== 8'h00) begin n_bad++; $display("FAIL rewrite_dark got=%h exp=00", water); end
    @(negedge clk);
    n_cmp++; if (water !== 8'hFF) begin n_bad++; $display("FAIL rewrite_lit got=%h exp=ff", water); end
    do_read(BASE + 32'hC, vld, got);
    n_cmp++; if (got !== 32'h0) begin n_bad++; $display("FAIL rewrite_status got=%h exp=0", got); end
    // Half-period 0 with blink_en set never blanks.
    do_write(BASE + 32'h8, 32'h0001_0000, 4'b1111);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      n_cmp++;
      if (water !== 8'hFF) begin n_bad++; $display("FAIL half0_k%0d got=%h exp=ff", k, water); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] got;
    logic        vld;
    // Read and write LED in the same cycle: old value comes back.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = BASE; wr_data = 32'h0000_005A; wr_be = 4'b0001;
    rd_en = 1'b1; rd_addr = BASE;
    @(negedge clk);
    wr_en = 1'b0; wr_be = 4'h0; rd_en = 1'b0;
    n_cmp++; if (rd_vld !== 1'b1) begin n_bad++; $display("FAIL rw_vld got=%b exp=1", rd_vld); end
    n_cmp++; if (rd_data !== 32'h0000_00FF) begin n_bad++; $display("FAIL rw_old got=%h exp=ff", rd_data); end
    @(negedge clk);
    n_cmp++; if (rd_vld !== 1'b0) begin n_bad++; $display("FAIL rd_vld_drop got=%b exp=0", rd_vld); end
    n_cmp++; if (rd_data !== 32'h0000_00FF) begin n_bad++; $display("FAIL rd_hold got=%h exp=ff", rd_data); end
    do_read(BASE, vld, got);
    n_cmp++; if (got !== 32'h0000_005A) begin n_bad++; $display("FAIL rw_new got=%h exp=5a", got); end
    do_read(BASE + 32'h8, vld, got);
    n_cmp++; if (got !== 32'h0001_0000) begin n_bad++; $display("FAIL rd_blink got=%h exp=10000", got); end
    do_read(BASE + 32'h4, vld, got);
    n_cmp++; if (got !== 32'h0001_1B03) begin n_bad++; $display("FAIL rd_seg got=%h exp=11b03", got); end
    // STATUS is read-only.
    do_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111);
    do_read(BASE + 32'hC, vld, got);
    n_cmp++; if (got !== 32'h0) begin n_bad++; $display("FAIL status_ro got=%h exp=0", got); end
    // Miss returns 0 with a valid pulse.
    do_read(BASE + 32'h10, vld, got);
    n_cmp++; if (vld !== 1'b1) begin n_bad++; $display("FAIL miss_vld got=%b exp=1", vld); end
    n_cmp++; if (got !== 32'h0) begin n_bad++; $display("FAIL miss_data got=%h exp=0", got); end
  endtask

  task automatic test_async_reset;
    logic [31:0] got;
    logic        vld;
    do_write(BASE + 32'h8, 32'h0001_0003, 4'b1111);
    repeat (3) @(negedge clk);
    rd_en = 1'b1; rd_addr = BASE;
    @(posedge clk);
    #2;
    n_cmp++; if (water !== 8'h5A) begin n_bad++; $display("FAIL pre_rst_led got=%h exp=5a", water); end
    rst = 1'b1;
    #1;
    n_cmp++; if (water !== 8'h00) begin n_bad++; $display("FAIL arst_water got=%h exp=00", water); end
    n_cmp++; if (seg1 !== 9'h100) begin n_bad++; $display("FAIL arst_seg1 got=%h exp=100", seg1); end
    n_cmp++; if (seg2 !== 9'h100) begin n_bad++; $display("FAIL arst_seg2 got=%h exp=100", seg2); end
    n_cmp++; if (rd_vld !== 1'b0) begin n_bad++; $display("FAIL arst_rd_vld got=%b exp=0", rd_vld); end
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL arst_rd_data got=%h exp=0", rd_data); end
    @(negedge clk);
    rst = 1'b0; rd_en = 1'b0;
    do_read(BASE, vld, got);
    n_cmp++; if (got !== 32'h0) begin n_bad++; $display("FAIL arst_led_reg got=%h exp=0", got); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset;
    test_led;
    test_seg;
    test_hex;
    test_blink;
    test_back_to_back;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
